// File: rtl/twos_compl_addsub.sv
// twos_compl_addsub: 16-bit two's-complement adder/subtractor, registered outputs.
//
// The arithmetic core is a ripple chain of full adders. For subtraction y is
// inverted bitwise and subc doubles as the carry-in, so x - y = x + ~y + 1.
// All outputs are registered, with a latency of exactly one cycle, no enable
// and no handshake.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst_n     in   1   asynchronous active-low reset; clears every output
//   x, y      in   16  signed operands
//   subc      in   1   0 = x + y, 1 = x - y (also the chain carry-in)
//   s         out  16  registered sum/difference (wraps modulo 2^16)
//   carry     out  1   registered carry out of bit 15 (subtract: 1 = no borrow)
//   overflow  out  1   registered signed-overflow flag
//   zero      out  1   registered s == 0   (TWOSCOMPL_FLAGS_EN only)
//   negative  out  1   registered s[15]    (TWOSCOMPL_FLAGS_EN only)
//
// Configuration macro: TWOSCOMPL_FLAGS_EN adds the zero and negative ports.

module twos_compl_addsub (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        subc,
  output logic [15:0] s,
  output logic        carry,
  output logic        overflow
`ifdef TWOSCOMPL_FLAGS_EN
  ,
  output logic        zero,
  output logic        negative
`endif
);

  logic [15:0] yb;
  logic [15:0] r;
  logic [16:0] c;

  logic [15:0] s_q;
  logic        carry_q;
  logic        overflow_q;

  // Ripple-carry chain; c[i] is the carry into bit i.
  always_comb begin
    yb   = y ^ {16{subc}};
    c    = '0;
    r    = '0;
    c[0] = subc;
    for (int i = 0; i < 16; i++) begin
      r[i]     = x[i] ^ yb[i] ^ c[i];
      c[i+1]   = (x[i] & yb[i]) | (c[i] & (x[i] ^ yb[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      s_q        <= r;
      carry_q    <= c[16];
      // Carries into and out of the sign bit disagree only on signed overflow.
      overflow_q <= c[16] ^ c[15];
    end
  end

  assign s        = s_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;

`ifdef TWOSCOMPL_FLAGS_EN
  logic zero_q;
  logic negative_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      zero_q     <= (r == 16'h0000);
      negative_q <= r[15];
    end
  end

  assign zero     = zero_q;
  assign negative = negative_q;
`endif

endmodule

// File: tb/tb_twos_compl_addsub.sv
// Directed self-checking bench for twos_compl_addsub. Each vector is applied
// just after a rising edge and its hand-computed result is checked 1 time unit
// after the following rising edge.

module tb_twos_compl_addsub;

  logic        clk;
  logic        rst_n;
  logic [15:0] x;
  logic [15:0] y;
  logic        subc;
  logic [15:0] s;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  int vectors;
  int miscompares;

  twos_compl_addsub dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .subc     (subc),
    .s        (s),
    .carry    (carry),
    .overflow (overflow)
`ifdef TWOSCOMPL_FLAGS_EN
    ,
    .zero     (zero),
    .negative (negative)
`endif
  );

`ifndef TWOSCOMPL_FLAGS_EN
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {s, carry, overflow, zero, negative}.
  logic [19:0] obs;
  assign obs = {s, carry, overflow, zero, negative};

  // Vector format: {x, y, subc, s_exp, carry_exp, overflow_exp}
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        subc;
    logic [15:0] s;
    logic        c;
    logic        v;
  } vec_t;

  task automatic test_reset();
    // Reset is asserted from time 0; outputs must be clear before any edge.
    #2;
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_initial got %h want %h", obs, 20'h0);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_held got %h want %h", obs, 20'h0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    vec_t tbl [4];
    logic [19:0] exp;
    tbl[0] = '{16'hAAAA, 16'hFFFF, 1'b0, 16'hAAA9, 1'b1, 1'b0};
    tbl[1] = '{16'hAAAA, 16'h0000, 1'b0, 16'hAAAA, 1'b0, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      x = tbl[i].x; y = tbl[i].y; subc = tbl[i].subc;
      @(posedge clk);
      #1;
`ifdef TWOSCOMPL_FLAGS_EN
      exp = {tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].s == 16'h0, tbl[i].s[15]};
`else
      exp = {tbl[i].s, tbl[i].c, tbl[i].v, 2'b00};
`endif
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL add[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_sub();
    vec_t tbl [4];
    logic [19:0] exp;
    tbl[0] = '{16'hAAAA, 16'hFFFF, 1'b1, 16'hAAAB, 1'b0, 1'b0};
    tbl[1] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      x = tbl[i].x; y = tbl[i].y; subc = tbl[i].subc;
      @(posedge clk);
      #1;
`ifdef TWOSCOMPL_FLAGS_EN
      exp = {tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].s == 16'h0, tbl[i].s[15]};
`else
      exp = {tbl[i].s, tbl[i].c, tbl[i].v, 2'b00};
`endif
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL sub[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t tbl [4];
    logic [19:0] exp;
    tbl[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[1] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      x = tbl[i].x; y = tbl[i].y; subc = tbl[i].subc;
      @(posedge clk);
      #1;
`ifdef TWOSCOMPL_FLAGS_EN
      exp = {tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].s == 16'h0, tbl[i].s[15]};
`else
      exp = {tbl[i].s, tbl[i].c, tbl[i].v, 2'b00};
`endif
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL ovf[%0d] got %h want %h", i, obs, exp);
      end
    end
  endtask

  // Inputs changed mid-cycle must not disturb the registered outputs.
  task automatic test_input_hold();
    logic [19:0] exp;
    x = 16'h0100; y = 16'h0023; subc = 1'b0;
    @(posedge clk);
    #1;
    x = 16'hFFFF; y = 16'hFFFF; subc = 1'b1;
    #3;
    exp = {16'h0123, 1'b0, 1'b0, 2'b00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL input_hold got %h want %h", obs, exp);
    end
    @(posedge clk);
    #1;
    // 0xFFFF - 0xFFFF = 0, no borrow
`ifdef TWOSCOMPL_FLAGS_EN
    exp = {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp = {16'h0000, 1'b1, 1'b0, 2'b00};
`endif
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL input_hold_next got %h want %h", obs, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [19:0] exp;
    x = 16'h7FFF; y = 16'h0001; subc = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (s !== 16'h8000) begin
      miscompares++;
      $display("FAIL areset_pre got %h want %h", s, 16'h8000);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL areset_immediate got %h want %h", obs, 20'h0);
    end
    x = 16'h0005; y = 16'h0003; subc = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (obs !== 20'h0) begin
      miscompares++;
      $display("FAIL areset_release got %h want %h", obs, 20'h0);
    end
    @(posedge clk);
    #1;
    exp = {16'h0002, 1'b1, 1'b0, 2'b00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL areset_first_load got %h want %h", obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    x           = 16'h0;
    y           = 16'h0;
    subc        = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_input_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
